// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
// The generator drives everything except the run enable.
interface vga_timing_gen_if;
    logic       en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       frame_start;

    modport master (
        input  en,
        output h_cnt, v_cnt, pix_tick, hsync, vsync, valid, frame_start
    );

    modport slave (
        output en,
        input  h_cnt, v_cnt, pix_tick, hsync, vsync, valid, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A clock divider produces a one-clock pixel strobe. The column and line counters
// advance on that strobe and run through the blanking region, so h_cnt/v_cnt go past
// the visible size and downstream logic can blank on them.
// hsync/vsync/valid are decoded from the live counters. They are then pushed through
// a short shift register so that they line up with the address register and BRAM read
// that sit downstream of h_cnt/v_cnt.
module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_DISP     = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_DISP     = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SYNC_DELAY = 2
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Compares are done one bit wider than the counters, so a total of up to
    // 1023 cannot wrap inside the sync window bounds.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISP);
    localparam logic [10:0] V_VIS    = 11'(V_DISP);
    localparam logic [10:0] HS_START = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_DISP + V_FP + V_SYNC);

    // {hsync, vsync, valid} with both syncs deasserted and the pixel blanked
    localparam logic [2:0] SYNC_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             frame_start_q, frame_start_d;

    logic             pix_tick;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_act;
    logic             vs_act;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             valid_raw;
    logic [2:0]       sync_raw;
    logic [2:0]       sync_out;

    assign h_ext = {1'b0, h_cnt_q};
    assign v_ext = {1'b0, v_cnt_q};

    // Pixel strobe: last divider phase while running; with CLK_DIV=1 it follows en.
    always_comb begin
        pix_tick = vga.en && (div_cnt_q == DIV_LAST);
    end

    // Wrap detection on the live counters
    always_comb begin
        h_wrap = (h_ext == H_LAST);
        v_wrap = (v_ext == V_LAST);
    end

    // Next-state for divider, raster counters and the frame-start pulse
    always_comb begin
        div_cnt_d     = div_cnt_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;

        if (vga.en) begin
            if (pix_tick) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end

        if (pix_tick) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                if (v_wrap) begin
                    v_cnt_d       = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers; reset returns the raster to the top-left corner
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Undelayed sync/valid decode from the live counters
    always_comb begin
        hs_act    = (h_ext >= HS_START) && (h_ext < HS_END);
        vs_act    = (v_ext >= VS_START) && (v_ext < VS_END);
        valid_raw = (h_ext < H_VIS) && (v_ext < V_VIS);
        hsync_raw = hs_act ? SYNC_POL : ~SYNC_POL;
        vsync_raw = vs_act ? SYNC_POL : ~SYNC_POL;
        sync_raw  = {hsync_raw, vsync_raw, valid_raw};
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign sync_out = sync_raw;
        end else begin : g_delay
            logic [2:0] sync_sr_q [SYNC_DELAY];
            logic [2:0] sync_sr_d [SYNC_DELAY];

            // Shift path; runs every clock, independent of en, so a stalled
            // raster still settles to the decode of the held counters.
            always_comb begin
                sync_sr_d[0] = sync_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    sync_sr_d[i] = sync_sr_q[i-1];
                end
            end

            // Delay stages; reset flushes them to inactive sync and blanked pixel
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        sync_sr_q[i] <= SYNC_IDLE;
                    end
                end else begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        sync_sr_q[i] <= sync_sr_d[i];
                    end
                end
            end

            assign sync_out = sync_sr_q[SYNC_DELAY-1];
        end
    endgenerate

    assign vga.h_cnt       = h_cnt_q;
    assign vga.v_cnt       = v_cnt_q;
    assign vga.pix_tick    = pix_tick;
    assign vga.frame_start = frame_start_q;
    assign vga.hsync       = sync_out[2];
    assign vga.vsync       = sync_out[1];
    assign vga.valid       = sync_out[0];

endmodule
